instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute/writeback sequencer that sits in front of ControlUnit_v. It owns the PC and the instruction register (IR), and handshakes with instruction memory. It presents a stable IR to the control unit and strobes the datapath execute and register-writeback enables. It also handles halt, illegal opcodes, datapath stalls and run/stop control.

---
 rtl/seq_pkg.sv | 30 +++
 rtl/instr_classify.sv | 37 +++
 rtl/instr_sequencer.sv | 148 ++++++++++++++
 tb/tb_instr_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and instruction field positions
// for the fetch/decode/execute/writeback sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] GRP_IMM = 2'b00;
  localparam logic [1:0] GRP_REG = 2'b01;
  localparam logic [1:0] GRP_SYS = 2'b10;
  localparam logic [1:0] GRP_LIT = 2'b11;

  localparam logic [2:0] SYS_HALT = 3'b000;

  // group field and system sub-opcode field
  localparam int GRP_HI = 15;
  localparam int GRP_LO = 14;
  localparam int SOP_HI = 13;
  localparam int SOP_LO = 11;

  // classifier sees only the top bits IR[15:11]
  localparam int CLS_W = GRP_HI - SOP_LO + 1;

endpackage

// File: rtl/instr_classify.sv
// instr_classify: sorts the top opcode bits of an
// instruction into execute / halt / illegal.
module instr_classify
  import seq_pkg::*;
(
  input  logic [CLS_W-1:0] op,
  output logic             is_exec,
  output logic             is_halt,
  output logic             is_illegal
);

  logic [1:0] grp;
  logic [2:0] sop;

  assign grp = op[GRP_HI-SOP_LO:GRP_LO-SOP_LO];
  assign sop = op[SOP_HI-SOP_LO:0];

  // one-hot classification of the opcode group
  always_comb begin
    is_exec    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    unique case (grp)
      GRP_IMM,
      GRP_REG,
      GRP_LIT: is_exec = 1'b1;
      GRP_SYS: begin
        if (sop == SYS_HALT)
          is_halt = 1'b1;
        else
          is_illegal = 1'b1;
      end
      default: is_exec = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle sequencer owning PC and IR,
// handshaking with instruction memory ahead of the control unit.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  output logic [15:0]      IR,
  output logic             ir_valid,
  output logic             ex_en,
  input  logic             stall,
  output logic             wb_en,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CLS_W-1:0]  cls_op;
  logic              c_exec;
  logic              c_halt;
  logic              c_illegal;

  // In FETCH classify the incoming word so the illegal
  // pulse can be registered on entry to DECODE; else
  // classify the held IR for the DECODE branch.
  assign cls_op = (state == S_FETCH)
                ? imem_data[GRP_HI:SOP_LO]
                : ir_q[GRP_HI:SOP_LO];

  instr_classify u_cls (
    .op         (cls_op),
    .is_exec    (c_exec),
    .is_halt    (c_halt),
    .is_illegal (c_illegal)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign IR          = ir_q;
  assign retired_cnt = cnt_q;

  // sequencer FSM with registered strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      cnt_q    <= '0;
      imem_req <= 1'b0;
      ir_valid <= 1'b0;
      ex_en    <= 1'b0;
      wb_en    <= 1'b0;
      illegal  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state    <= S_DECODE;
            ir_q     <= imem_data;
            pc_q     <= pc_q + PC_ONE;
            imem_req <= 1'b0;
            ir_valid <= 1'b1;
            illegal  <= c_illegal;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            c_exec: begin
              state <= S_EXEC;
              ex_en <= 1'b1;
            end
            c_halt: begin
              state    <= S_HALT;
              ir_valid <= 1'b0;
              halted   <= 1'b1;
            end
            c_illegal: begin
              ir_valid <= 1'b0;
              if (run) begin
                state    <= S_FETCH;
                imem_req <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end
            default: begin
              state    <= S_IDLE;
              ir_valid <= 1'b0;
            end
          endcase
        end
        S_EXEC: begin
          if (!stall) begin
            state <= S_WB;
            ex_en <= 1'b0;
            wb_en <= 1'b1;
          end
        end
        S_WB: begin
          ir_valid <= 1'b0;
          cnt_q    <= cnt_q + CNT_ONE;
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          ir_valid <= 1'b0;
          ex_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: random program/ack/stall/run stimulus
// with a queued scoreboard, plus a directed PC-wrap check.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, imem_ack, stall;
  logic [15:0] imem_data;
  logic        imem_req, ir_valid, ex_en, wb_en, halted, illegal;
  logic [15:0] imem_addr, ir, pc, retired_cnt;

  instr_sequencer #(
    .PC_W(16), .RESET_PC(16'h0000), .CNT_W(16)
  ) dut (
    .CLK(clk), .RST(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .IR(ir), .ir_valid(ir_valid), .ex_en(ex_en),
    .stall(stall), .wb_en(wb_en), .pc(pc),
    .halted(halted), .illegal(illegal),
    .retired_cnt(retired_cnt)
  );

  logic        rst2, run2, ack2, stall2;
  logic [15:0] data2;
  logic        req2, irv2, ex2, wb2, halt2, ill2;
  logic [15:0] addr2, ir2, pc2, ret2;

  instr_sequencer #(
    .PC_W(16), .RESET_PC(16'hFFFF), .CNT_W(16)
  ) dut_wrap (
    .CLK(clk), .RST(rst2), .run(run2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_data(data2),
    .IR(ir2), .ir_valid(irv2), .ex_en(ex2),
    .stall(stall2), .wb_en(wb2), .pc(pc2),
    .halted(halt2), .illegal(ill2),
    .retired_cnt(ret2)
  );

  typedef enum int {K_EXEC, K_HALT, K_ILL} kind_e;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] word;
    kind_e       kind;
    int          s;
    int          ack_cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          model_ret = 0;
  bit          halt_seen = 1'b0;
  logic [15:0] halt_pc = '0;
  logic [15:0] model_pc = '0;
  logic [15:0] mem [256];
  int          wait_left = 0;
  int          stall_left = 0;
  int          halt_cnt = 0;
  int          acks = 0;
  int          resets = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // spec-level classification of a fetched word
  function automatic kind_e ref_kind(input logic [15:0] w);
    if (w[15:14] != 2'b10) return K_EXEC;
    if (w[13:11] == 3'd0) return K_HALT;
    return K_ILL;
  endfunction

  function automatic logic [15:0] gen_word();
    int r;
    logic [15:0] w;
    r = $urandom_range(0, 99);
    w = 16'($urandom);
    if (r < 30) w[15:14] = 2'b00;
    else if (r < 55) w[15:14] = 2'b01;
    else if (r < 80) w[15:14] = 2'b11;
    else if (r < 96) begin
      w[15:14] = 2'b10;
      w[13:11] = 3'($urandom_range(1, 7));
    end else begin
      w[15:14] = 2'b10;
      w[13:11] = 3'd0;
    end
    return w;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = gen_word();
  endtask

  // scoreboard monitor, sampled 1ns after each rising edge
  task automatic monitor_cycle();
    exp_t e;
    if (halt_seen) begin
      check("halt_hold",
            32'({halted, imem_req, ex_en, wb_en, illegal}),
            32'(5'b10000));
      check("halt_pc", 32'(pc), 32'(halt_pc));
    end
    if (q.size() > 0 && cyc == q[0].ack_cyc) begin
      check("decode_valid", 32'(ir_valid), 32'd1);
      check("decode_ir", 32'(ir), 32'(q[0].word));
    end
    if (illegal) begin
      check("ill_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("ill_kind", 32'(e.kind), 32'(K_ILL));
        check("ill_cycle", 32'(cyc), 32'(e.ack_cyc));
        check("ill_strobes", 32'({ex_en, wb_en}), 32'd0);
        check("ill_ret", 32'(retired_cnt), 32'(16'(model_ret)));
      end
    end
    if (wb_en) begin
      check("wb_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wb_kind", 32'(e.kind), 32'(K_EXEC));
        check("wb_cycle", 32'(cyc), 32'(e.ack_cyc + 2 + e.s));
        check("wb_ir", 32'(ir), 32'(e.word));
        check("wb_pc", 32'(pc), 32'(16'(e.addr + 16'd1)));
        check("wb_ret", 32'(retired_cnt), 32'(16'(model_ret)));
        check("wb_flags", 32'({ex_en, ir_valid}), 32'b01);
        model_ret++;
      end
    end
    if (halted && !halt_seen) begin
      check("halt_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("halt_kind", 32'(e.kind), 32'(K_HALT));
        check("halt_cycle", 32'(cyc), 32'(e.ack_cyc + 1));
        halt_pc = 16'(e.addr + 16'd1);
        check("halt_pc_entry", 32'(pc), 32'(halt_pc));
        check("halt_ret", 32'(retired_cnt), 32'(16'(model_ret)));
      end
      halt_seen = 1'b1;
    end
    if (q.size() > 0 && cyc > q[0].ack_cyc + q[0].s + 4) begin
      check("event_late", 32'(cyc), 32'(q[0].ack_cyc + q[0].s + 2));
      void'(q.pop_front());
    end
  endtask

  bit mon_en = 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) monitor_cycle();
    end
  end

  // one negedge of stimulus: reset, run, memory responder, stall
  task automatic step();
    exp_t e;
    bit do_rst;
    @(negedge clk);
    if (rst) begin
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_ir", 32'(ir), 32'h0);
      check("rst_cnt", 32'(retired_cnt), 32'h0);
      check("rst_strobes",
            32'({imem_req, ir_valid, ex_en, wb_en, illegal, halted}),
            32'h0);
      rst = 1'b0;
    end
    run = ($urandom_range(0, 9) != 0);
    do_rst = 1'b0;
    if (halted) begin
      run = 1'b1;
      halt_cnt++;
      if (halt_cnt >= 20) do_rst = 1'b1;
    end else if (ex_en && stall_left > 1 && $urandom_range(0, 7) == 0) begin
      do_rst = 1'b1;
    end else if (imem_req && $urandom_range(0, 40) == 0) begin
      do_rst = 1'b1;
    end
    if (do_rst) begin
      rst       = 1'b1;
      imem_ack  = imem_req;
      imem_data = 16'($urandom);
      stall     = 1'($urandom_range(0, 1));
      q.delete();
      model_ret = 0;
      model_pc  = 16'h0000;
      halt_seen = 1'b0;
      halt_cnt  = 0;
      wait_left = $urandom_range(0, 3);
      resets++;
      fill_mem();
      return;
    end
    if (imem_req) begin
      if (wait_left > 0) begin
        wait_left--;
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
      end else begin
        check("fetch_addr", 32'(imem_addr), 32'(model_pc));
        e.addr    = model_pc;
        e.word    = mem[imem_addr[7:0]];
        e.kind    = ref_kind(e.word);
        e.s       = $urandom_range(0, 4);
        e.ack_cyc = cyc + 1;
        q.push_back(e);
        imem_ack   = 1'b1;
        imem_data  = e.word;
        stall_left = e.s;
        model_pc   = model_pc + 16'd1;
        wait_left  = $urandom_range(0, 3);
        acks++;
      end
    end else begin
      imem_ack  = ($urandom_range(0, 7) == 0);
      imem_data = 16'($urandom);
    end
    if (ex_en) begin
      stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end else begin
      stall = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0;
    stall = 1'b0; imem_data = '0;
    rst2 = 1'b1; run2 = 1'b0; ack2 = 1'b0;
    stall2 = 1'b0; data2 = '0;
    fill_mem();
    mem[0] = 16'h0901;
    mem[1] = 16'h6048;
    mem[2] = 16'h6C4A;
    mem[3] = 16'h8800;
    mem[4] = 16'h8000;

    for (int i = 0; i < 6000; i++) step();

    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    imem_ack = 1'b0;
    q.delete();
    halt_seen = 1'b0;
    check("progress_acks", 32'(acks >= 200), 32'd1);
    check("progress_resets", 32'(resets >= 5), 32'd1);

    @(negedge clk);
    check("w_rst_pc", 32'(pc2), 32'hFFFF);
    check("w_rst_ret", 32'(ret2), 32'h0);
    rst2 = 1'b0;
    run2 = 1'b1;
    @(negedge clk);
    check("w_req", 32'(req2), 32'd1);
    check("w_addr", 32'(addr2), 32'hFFFF);
    ack2  = 1'b1;
    data2 = 16'hD801;
    @(negedge clk);
    ack2 = 1'b0;
    run2 = 1'b0;
    check("w_pc", 32'(pc2), 32'h0000);
    check("w_ir", 32'(ir2), 32'hD801);
    check("w_dec", 32'({irv2, ex2, ill2}), 32'b100);
    @(negedge clk);
    check("w_ex", 32'({ex2, wb2}), 32'b10);
    @(negedge clk);
    check("w_wb", 32'({ex2, wb2}), 32'b01);
    check("w_ret_wb", 32'(ret2), 32'h0);
    @(negedge clk);
    check("w_ret", 32'(ret2), 32'h1);
    check("w_idle", 32'({req2, irv2, ex2, wb2, halt2}), 32'h0);
    check("w_pc_end", 32'(pc2), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
